// File: rtl/bcd_a_binario_pkg.sv
// bcd_pkg: shared types and constants for the BCD-to-binary converter.
// Field layout of the 3-digit BCD word and FSM state encoding.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int ITER    = 9;
  localparam int BCD_W   = 10;
  localparam int BIN_W   = 9;
  localparam int DIGIT_W = 4;
  localparam int HUND_W  = 2;
  localparam int CNT_W   = 4;

  localparam int UNITS_LSB = 0;
  localparam int TENS_LSB  = 4;
  localparam int HUND_LSB  = 8;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  function automatic logic digit_bad(logic [DIGIT_W-1:0] d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_a_binario_if.sv
// bcd_a_binario_if: input and result valid/ready channels of the converter.
// master drives BCD words and accepts results; slave is the converter.
interface bcd_a_binario_if;
  import bcd_pkg::*;

  logic [BCD_W-1:0] bcd_in;
  logic             in_valid;
  logic             in_ready;
  logic [BIN_W-1:0] bin_out;
  logic             out_valid;
  logic             out_ready;
  logic             out_err;

  modport master (
    output bcd_in, in_valid, out_ready,
    input  in_ready, bin_out, out_valid, out_err
  );

  modport slave (
    input  bcd_in, in_valid, out_ready,
    output in_ready, bin_out, out_valid, out_err
  );

endinterface

// File: rtl/bcd_a_binario_bloque_restador.sv
// bloque_restador: BCD digit corrector, subtracts 3 when the digit is >= 8.
// Inverse of the add-3 cell of the binary-to-BCD direction.
module bloque_restador
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_d,
  output logic [DIGIT_W-1:0] o_d
);

  assign o_d = i_d[3] ? i_d - 4'd3 : i_d;

endmodule

// File: rtl/bcd_a_binario.sv
// bcd_a_binario: reverse double-dabble, 3-digit BCD to 9-bit binary.
// Define BCD_CHECK_EN to flag tens/units > 9 on out_err.
module bcd_a_binario
  import bcd_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  bcd_a_binario_if.slave bus
);

  localparam int SH_W = BCD_W + BIN_W;

  state_t             r_state, w_state;
  logic [BCD_W-1:0]   r_bcd, w_bcd;
  logic [BIN_W-1:0]   r_bin, w_bin;
  logic [BIN_W-1:0]   r_out, w_out;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [SH_W-1:0]    w_sh;
  logic [DIGIT_W-1:0] w_tens, w_units;
  logic [BIN_W-1:0]   w_res;
  logic               w_last;

  assign w_sh   = {r_bcd, r_bin} >> 1;
  assign w_last = (r_cnt == CNT_LAST);

  bloque_restador u_tens (
    .i_d (w_sh[BIN_W+TENS_LSB +: DIGIT_W]),
    .o_d (w_tens)
  );

  bloque_restador u_units (
    .i_d (w_sh[BIN_W+UNITS_LSB +: DIGIT_W]),
    .o_d (w_units)
  );

`ifdef BCD_CHECK_EN
  logic r_flag;
  logic r_err;

  // Flag is captured with the operand and only surfaces in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flag <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE:
          if (bus.in_valid)
            r_flag <= digit_bad(bus.bcd_in[TENS_LSB +: DIGIT_W]) |
                      digit_bad(bus.bcd_in[UNITS_LSB +: DIGIT_W]);
        SHIFT:
          if (w_last) r_err <= r_flag;
        DONE:
          if (bus.out_ready) r_err <= 1'b0;
        default: ;
      endcase
    end
  end

  assign w_res       = r_flag ? '0 : w_sh[BIN_W-1:0];
  assign bus.out_err = r_err;
`else
  assign w_res       = w_sh[BIN_W-1:0];
  assign bus.out_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_bcd   <= '0;
      r_bin   <= '0;
      r_out   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_bcd   <= w_bcd;
      r_bin   <= w_bin;
      r_out   <= w_out;
      r_cnt   <= w_cnt;
    end
  end

  always_comb begin
    w_state = r_state;
    w_bcd   = r_bcd;
    w_bin   = r_bin;
    w_out   = r_out;
    w_cnt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_state = SHIFT;
          w_bcd   = bus.bcd_in;
          w_bin   = '0;
          w_cnt   = '0;
        end
      end
      SHIFT: begin
        // Hundreds never reaches 8 after a shift, so it is not corrected.
        w_bcd = {w_sh[SH_W-1 -: HUND_W], w_tens, w_units};
        w_bin = w_sh[BIN_W-1:0];
        w_cnt = r_cnt + 4'd1;
        if (w_last) begin
          w_state = DONE;
          w_out   = w_res;
        end
      end
      DONE: begin
        if (bus.out_ready) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.bin_out   = r_out;

endmodule

// File: tb/tb_bcd_a_binario.sv
// tb_bcd_a_binario: randomized self-checking bench for bcd_a_binario.
// Expected results come from 100*h + 10*t + u arithmetic.
module tb_bcd_a_binario;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  bcd_a_binario_if bus();

  bcd_a_binario dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int ref_val(logic [9:0] v);
    return int'(v[9:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [9:0] enc(int n);
    logic [1:0] h;
    logic [3:0] t;
    logic [3:0] u;
    h = 2'(n / 100);
    t = 4'((n / 10) % 10);
    u = 4'(n % 10);
    return {h, t, u};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one transaction from IDLE; returns result and accept-to-valid cycles.
  task automatic run(input logic [9:0] v, output logic [8:0] b,
                     output logic e, output int lat);
    bus.bcd_in    = v;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    b = bus.bin_out;
    e = bus.out_err;
    tick();
  endtask

  task automatic test_reset;
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.bcd_in   = enc(123);
    repeat (3) tick();
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.bin_out !== 9'd0 || bus.out_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: rdy=%b vld=%b bin=%h err=%b want 1 0 000 0",
               bus.in_ready, bus.out_valid, bus.bin_out, bus.out_err);
    end
    bus.in_valid = 1'b0;
    reset = 1'b0;
    tick();
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ignore_valid: in_ready=%b want 1", bus.in_ready);
    end
  endtask

  task automatic test_nominal;
    int lat;
    bus.bcd_in    = 10'b10_0101_0101;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL nominal_busy: in_ready=%b want 0", bus.in_ready);
    end
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    total++;
    if (lat !== 9) begin
      bad++;
      $display("FAIL nominal_latency: got %0d want 9", lat);
    end
    total++;
    if (bus.bin_out !== 9'h0FF) begin
      bad++;
      $display("FAIL nominal_value: got %h want 0ff", bus.bin_out);
    end
    tick();
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL nominal_return: rdy=%b vld=%b want 1 0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_endpoints;
    int pts[4] = '{0, 399, 256, 255};
    logic [8:0] b;
    logic e;
    int lat;
    foreach (pts[i]) begin
      run(enc(pts[i]), b, e, lat);
      total++;
      if (b !== 9'(pts[i]) || lat !== 9 || e !== 1'b0) begin
        bad++;
        $display("FAIL endpoint_%0d: bin=%h lat=%0d err=%b want %h 9 0",
                 pts[i], b, lat, e, 9'(pts[i]));
      end
    end
  endtask

  task automatic test_sweep;
    int order[400];
    int j;
    int tmp;
    logic [9:0] v;
    logic [8:0] b;
    logic e;
    int lat;
    for (int i = 0; i < 400; i++) order[i] = i;
    for (int i = 399; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      v = enc(order[i]);
      run(v, b, e, lat);
      total++;
      if (int'(b) !== ref_val(v) || lat !== 9) begin
        bad++;
        $display("FAIL sweep_%0d: bin=%0d lat=%0d want %0d 9",
                 order[i], b, lat, ref_val(v));
      end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    bit held_ok;
    bus.bcd_in    = enc(128);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    total++;
    if (lat !== 9) begin
      bad++;
      $display("FAIL bp_latency: got %0d want 9", lat);
    end
    held_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid !== 1'b1 || bus.bin_out !== 9'h080 ||
          bus.in_ready !== 1'b0)
        held_ok = 1'b0;
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.bcd_in   = enc(int'($urandom_range(0, 399)));
      tick();
    end
    total++;
    if (!held_ok || bus.out_valid !== 1'b1 || bus.bin_out !== 9'h080) begin
      bad++;
      $display("FAIL bp_hold: vld=%b bin=%h want 1 080",
               bus.out_valid, bus.bin_out);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: vld=%b rdy=%b want 0 1",
               bus.out_valid, bus.in_ready);
    end
    tick();
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_single: rdy=%b vld=%b want 1 0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_midop;
    bit quiet;
    logic [8:0] b;
    logic e;
    int lat;
    bus.bcd_in    = enc(321);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.bin_out !== 9'd0 ||
        bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midop_reset: vld=%b bin=%h rdy=%b want 0 000 1",
               bus.out_valid, bus.bin_out, bus.in_ready);
    end
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid !== 1'b0) quiet = 1'b0;
      tick();
    end
    total++;
    if (!quiet) begin
      bad++;
      $display("FAIL midop_no_partial: out_valid seen 1 want 0");
    end
    run(enc(50), b, e, lat);
    total++;
    if (b !== 9'h032 || lat !== 9) begin
      bad++;
      $display("FAIL midop_fresh: bin=%h lat=%0d want 032 9", b, lat);
    end
  endtask

  task automatic test_err;
    logic [8:0] b;
    logic e;
    int lat;
    logic [9:0] v;
    run(10'b0_1010_0011, b, e, lat);
    total++;
`ifdef BCD_CHECK_EN
    if (e !== 1'b1 || b !== 9'd0 || lat !== 9) begin
      bad++;
      $display("FAIL err_flag: err=%b bin=%h lat=%0d want 1 000 9", e, b, lat);
    end
`else
    if (e !== 1'b0 || lat !== 9) begin
      bad++;
      $display("FAIL err_off: err=%b lat=%0d want 0 9", e, lat);
    end
`endif
    total++;
    if (bus.out_err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: out_err=%b want 0", bus.out_err);
    end
    run(enc(99), b, e, lat);
    total++;
    if (e !== 1'b0 || b !== 9'h063) begin
      bad++;
      $display("FAIL err_next: err=%b bin=%h want 0 063", e, b);
    end
    for (int i = 0; i < 6; i++) begin
      v = {2'($urandom_range(0, 3)), 4'($urandom_range(10, 15)),
           4'($urandom_range(0, 15))};
      run(v, b, e, lat);
      total++;
`ifdef BCD_CHECK_EN
      if (e !== 1'b1 || b !== 9'd0 || lat !== 9) begin
        bad++;
        $display("FAIL err_rand_%h: err=%b bin=%h lat=%0d want 1 000 9",
                 v, e, b, lat);
      end
`else
      if (e !== 1'b0 || lat !== 9) begin
        bad++;
        $display("FAIL err_rand_%h: err=%b lat=%0d want 0 9", v, e, lat);
      end
`endif
    end
  endtask

  // Accepts land every 11 edges with in_valid and out_ready held high.
  task automatic test_back_to_back;
    int vals[65];
    int exp_n;
    logic exp_v;
    for (int c = 0; c < 65; c++) vals[c] = int'($urandom_range(0, 399));
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 65; c++) begin
      bus.bcd_in = enc(vals[c]);
      if (c == 64) bus.in_valid = 1'b0;
      tick();
      exp_v = ((c % 11) == 9);
      exp_n = exp_v ? vals[c - 9] : 0;
      total++;
      if (bus.out_valid !== exp_v ||
          (exp_v && int'(bus.bin_out) !== exp_n)) begin
        bad++;
        $display("FAIL busy_c%0d: vld=%b bin=%0d want %b %0d",
                 c, bus.out_valid, bus.bin_out, exp_v, exp_n);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL busy_end: rdy=%b vld=%b want 1 0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.bcd_in    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_nominal();
    test_endpoints();
    test_sweep();
    test_backpressure();
    test_reset_midop();
    test_err();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_a_binario.md
Name: bcd_a_binario

Overview:
Sequential BCD-to-binary converter. It is the inverse of the counter's binary-to-BCD display path, and takes the 3-digit BCD value {hundreds[1:0], tens[3:0], units[3:0]}, as produced by the millisecond counter's display path or entered as a preset.
- Algorithm: iterative reverse double-dabble, one right-shift plus subtract-3 correction per clock.
- Result: 9-bit binary value, returned over a valid/ready handshake.
- Use: lets BCD presets and compare values be loaded into the binary counter.

Parameters:
ITER, 9, number of shift/correct iterations; equals binary output width; fixed at 9 (covers 0..399); other values unsupported.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
bcd_in  input  10  {hundreds[1:0], tens[3:0], units[3:0]}
in_valid  input  1  bcd_in valid
in_ready  output  1  converter can accept an input (IDLE)
bin_out  output  9  binary result, stable while out_valid
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_err  output  1  invalid BCD digit flag (see Optional Feature)

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: state=IDLE, in_ready=1, out_valid=0, bin_out=0, out_err=0, iteration counter=0, internal BCD/binary shift registers=0.
- While reset is high, in_valid is ignored.
- Reset mid-conversion or in DONE aborts at the next edge; no partial result is ever presented.

States:
- IDLE: in_ready=1. On an edge with in_valid=1:
  - capture bcd_in into the BCD shift register;
  - clear the binary register and the counter;
  - go to SHIFT.
- SHIFT: in_ready=0. Each edge performs one iteration:
  - shift the {BCD, binary} 19-bit concatenation right by 1;
  - after the shift, each 4-bit digit (tens, units) with value >= 8 is reduced by 3;
  - the hundreds field, now 2 bits incl. shifted-in bits, needs no correction beyond the tens digit logic;
  - counter increments.
  - After the ITER-th iteration edge: go to DONE, load bin_out from the binary register, set out_valid=1.
- DONE: out_valid=1, bin_out and out_err held stable. On an edge with out_ready=1: out_valid=0, return to IDLE.
  - in_ready stays 0 in DONE; there is no same-cycle accept of a new input.

Latency and throughput:
- Input accepted at edge E0 → out_valid high after edge E9 (9 cycles).
- Minimum initiation interval is 11 cycles with out_ready tied high.

Arithmetic:
- Result = 100*h + 10*t + u, range 0..399.
- bin_out[8] is set only for values >= 256.
- in_valid asserted while not in IDLE is ignored; no buffering.

Optional Feature:
Macro: BCD_CHECK_EN
- Defined:
  - On capture, flag an error if tens > 9 or units > 9.
  - The conversion still runs for the full latency.
  - In DONE: out_err=1 and bin_out=0 for a flagged input; out_err=0 otherwise.
  - out_err resets to 0 and is cleared on leaving DONE.
- Undefined:
  - out_err is tied to 0.
  - An invalid digit produces an unspecified but deterministic bin_out.
  - Timing is unchanged in both cases.

Decomposition:
- Shared package (bcd_pkg):
  - state encoding IDLE/SHIFT/DONE (2 bits);
  - constants ITER=9, BCD_W=10, BIN_W=9, DIGIT_W=4;
  - digit field offsets (units 3:0, tens 7:4, hundreds 9:8).
- One natural sub-module, bloque_restador: 4-bit combinational "if >= 8 subtract 3" digit corrector.
  - Instantiated twice (tens, units).
  - It is the inverse of the add-3 cell used by the binary-to-BCD direction.

Test Plan:
- Nominal: reset, then bcd_in=10'b10_0101_0101 (255) with in_valid one cycle, out_ready=1 → in_ready low next cycle; out_valid exactly 9 cycles after accept; bin_out=9'h0FF; in_ready back to 1 one cycle after the handshake.
- Endpoints: input 000 → bin_out=0. Input 399 (11_1001_1001) → bin_out=9'h18F. Input 256 → 9'h100. Sweep all 400 valid codes against a reference model.
- Backpressure: convert 128 with out_ready=0 for 20 cycles → out_valid and bin_out=9'h080 held stable, in_valid pulses ignored; release out_ready → single handshake, return to IDLE.
- Reset mid-op: assert reset during iteration 4 of converting 321 → next cycle out_valid=0, bin_out=0, in_ready=1; a fresh conversion of 050 yields 9'h032.
- BCD_CHECK_EN: input tens=4'hA (0_1010_0011) → out_err=1, bin_out=0 in DONE. Next valid input 099 → out_err=0, bin_out=9'h063. With the macro undefined, out_err stays 0 throughout.
- Busy input: in_valid held high continuously with changing bcd_in → only the value present at each IDLE accept edge is converted; one result per 11 cycles with out_ready=1.
